debounce_bank: RTL and testbench

Parametrised multi-channel debouncer for the keypad front end: the successor to the single-window 4-bit debouncer. Each of `N_CH` raw inputs gets its own two-flop synchroniser, stability counter and state, so channels settle independently. The block emits per-channel debounced levels, one-cycle press/release pulses and an optional auto-repeat pulse train. It sits between the keypad column pins and the scanner/decoder FSM.

---
 rtl/debounce_bank.sv | 74 +++++++
 tb/tb_debounce_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: per-channel two-flop sync + stability-window debouncer with
// one-cycle rise/fall pulses and optional auto-repeat while a key is held.
module debounce_bank #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 960000,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] raw,
  output logic [N_CH-1:0] stable,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] rep,
  output logic            any_event
);
  localparam int CW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);
  logic [N_CH-1:0] s1, s;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1        <= '0;
      s         <= '0;
      any_event <= 1'b0;
    end else begin
      s1        <= raw;
      s         <= s1;
      any_event <= |(rise | fall | rep);
    end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic st, ri, fa, acc;
    // acc: the mismatch window is complete, take the new level this edge
    assign acc = (s[i] != st) && (cnt == CMAX);
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        cnt <= '0;
        st  <= 1'b0;
        ri  <= 1'b0;
        fa  <= 1'b0;
      end else begin
        cnt <= (s[i] == st || acc) ? '0 : cnt + 1'b1;
        st  <= acc ? s[i] : st;
        ri  <= acc & s[i];
        fa  <= acc & ~s[i];
      end
    assign stable[i] = st;
    assign rise[i]   = ri;
    assign fall[i]   = fa;
    if (REPEAT_DELAY > 0) begin : g_rep
      localparam int RW = $clog2(REPEAT_DELAY + 1);
      // a zero period parks the counter at the delay value so it never fires again
      localparam int RELOAD = REPEAT_PERIOD == 0 ? REPEAT_DELAY :
                              REPEAT_PERIOD > REPEAT_DELAY ? 0 : REPEAT_DELAY - REPEAT_PERIOD;
      logic [RW-1:0] rcnt;
      logic rp, fire;
      assign fire = st && !acc && (rcnt == RW'(REPEAT_DELAY - 1));
      always_ff @(posedge clk or negedge reset)
        if (!reset) begin
          rcnt <= '0;
          rp   <= 1'b0;
        end else begin
          rcnt <= (!st || acc) ? '0 :
                  fire ? RW'(RELOAD) :
                  (rcnt == RW'(REPEAT_DELAY)) ? rcnt : rcnt + 1'b1;
          rp   <= fire;
        end
      assign rep[i] = rp;
    end else begin : g_norep
      assign rep[i] = 1'b0;
    end
  end
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: table, directed and random checks of debounce_bank against
// an event-level reference model (mismatch run lengths and time-since-press).
module tb_debounce_bank;
  localparam int SC = 20;
  localparam int RD = 50;
  localparam int RP = 10;
  logic clk, reset;
  logic [3:0] raw;
  logic [3:0] stable, rise, fall, rep, stable2, rise2, fall2, rep2;
  logic any_event, any_event2;
  int checks = 0, errors = 0;

  debounce_bank #(.N_CH(4), .STABLE_CYCLES(SC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_dut (
    .clk(clk), .reset(reset), .raw(raw), .stable(stable), .rise(rise), .fall(fall),
    .rep(rep), .any_event(any_event));
  debounce_bank #(.N_CH(4), .STABLE_CYCLES(SC), .REPEAT_DELAY(0), .REPEAT_PERIOD(0)) u_norep (
    .clk(clk), .reset(reset), .raw(raw), .stable(stable2), .rise(rise2), .fall(fall2),
    .rep(rep2), .any_event(any_event2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] m_sh1, m_sh, m_st, m_rise, m_fall, m_rep;
  logic m_any, m_any2;
  int mm[4], since[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sh1 = 0; m_sh = 0; m_st = 0; m_rise = 0; m_fall = 0; m_rep = 0; m_any = 0; m_any2 = 0;
    for (int i = 0; i < 4; i++) begin mm[i] = 0; since[i] = 0; end
  endtask

  // one clock edge: accept after SC consecutive disagreeing samples; repeat at RD, RD+RP, ...
  task automatic model_step();
    logic [3:0] nr, nf, np;
    nr = 0; nf = 0; np = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_sh[i] != m_st[i]) begin
        mm[i]++;
        if (mm[i] == SC) begin
          mm[i] = 0;
          if (m_sh[i]) nr[i] = 1'b1; else nf[i] = 1'b1;
        end
      end else mm[i] = 0;
      if (m_st[i] && !nf[i]) begin
        since[i]++;
        if (since[i] >= RD && (since[i] - RD) % RP == 0) np[i] = 1'b1;
      end
      if (nr[i]) since[i] = 0;
    end
    m_any  = |(m_rise | m_fall | m_rep);
    m_any2 = |(m_rise | m_fall);
    m_st   = m_st ^ nr ^ nf;
    m_rise = nr; m_fall = nf; m_rep = np;
    m_sh   = m_sh1; m_sh1 = raw;
  endtask

  task automatic cmp_all();
    chk("stable", stable, m_st);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("rep", rep, m_rep);
    chk("any_event", any_event, m_any);
    chk("norep_stable", stable2, m_st);
    chk("norep_rise", rise2, m_rise);
    chk("norep_fall", fall2, m_fall);
    chk("norep_rep", rep2, 0);
    chk("norep_any", any_event2, m_any2);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_all();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_out"}, {stable, rise, fall, rep, 3'b0, any_event}, 0);
    chk({nm, "_out2"}, {stable2, rise2, fall2, rep2, 3'b0, any_event2}, 0);
  endtask

  typedef struct {
    logic [3:0] raw;
    int         cycles;
    logic [3:0] exp_stable;
    logic [3:0] exp_rise;
    logic [3:0] exp_fall;
  } vec_t;
  vec_t vt[8];

  initial begin
    logic [3:0] rs, fs;
    int hits[$];
    int n, at;
    logic seen;
    vt[0] = '{4'b0000, 5,  4'b0000, 4'b0000, 4'b0000};
    vt[1] = '{4'b0010, 25, 4'b0010, 4'b0010, 4'b0000};
    vt[2] = '{4'b0000, 25, 4'b0000, 4'b0000, 4'b0010};
    vt[3] = '{4'b0100, 19, 4'b0000, 4'b0000, 4'b0000};
    vt[4] = '{4'b0000, 25, 4'b0000, 4'b0000, 4'b0000};
    vt[5] = '{4'b1000, 25, 4'b1000, 4'b1000, 4'b0000};
    vt[6] = '{4'b0001, 25, 4'b0001, 4'b0001, 4'b1000};
    vt[7] = '{4'b0000, 25, 4'b0000, 4'b0000, 4'b0001};
    reset = 1'b0; raw = 4'b0;
    model_reset();
    #1 chk_zero("reset_state");
    @(negedge clk) reset = 1'b1;

    for (int v = 0; v < 8; v++) begin
      raw = vt[v].raw; rs = 0; fs = 0;
      repeat (vt[v].cycles) begin tick(); rs |= rise; fs |= fall; end
      chk($sformatf("vec%0d_stable", v), stable, vt[v].exp_stable);
      chk($sformatf("vec%0d_rise", v), rs, vt[v].exp_rise);
      chk($sformatf("vec%0d_fall", v), fs, vt[v].exp_fall);
    end

    // clean press: stable/rise at e0+21, any_event at e0+22
    raw = 4'b0010;
    repeat (21) tick();
    chk("press_early", stable, 4'b0000);
    tick();
    chk("press_stable", stable, 4'b0010);
    chk("press_rise", rise, 4'b0010);
    tick();
    chk("press_rise_gone", rise, 4'b0000);
    chk("press_any", any_event, 1);
    raw = 4'b0000;
    repeat (25) tick();

    // bounce then hold from eb: single rise at eb+21
    foreach (vt[v]) if (v < 4) begin raw = v[0] ? 4'b0000 : 4'b0001; tick(); end
    raw = 4'b0001; n = 0; at = -1; fs = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (rise[0]) begin n++; at = k; end
      fs |= fall;
    end
    chk("bounce_rise_n", n, 1);
    chk("bounce_rise_at", at, 21);
    chk("bounce_no_fall", fs, 0);
    raw = 4'b0000;
    repeat (25) tick();

    // simultaneous rise on ch0 and fall on ch3
    raw = 4'b1000;
    repeat (25) tick();
    raw = 4'b0001;
    repeat (21) tick();
    chk("simul_early", {rise, fall}, 0);
    tick();
    chk("simul_rise", rise, 4'b0001);
    chk("simul_fall", fall, 4'b1000);
    raw = 4'b0000;
    repeat (25) tick();

    // auto-repeat on ch1
    raw = 4'b0010; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin tick(); seen = rise[1]; end
    chk("rep_rise_seen", seen, 1);
    fs = 0;
    for (int k = 1; k <= 75; k++) begin
      tick();
      if (rep[1]) hits.push_back(k);
      fs |= rep2;
    end
    chk("rep_count", hits.size(), 3);
    foreach (hits[j]) chk($sformatf("rep_at%0d", j), hits[j], 50 + 10 * j);
    chk("rep_disabled", fs, 0);
    raw = 4'b0000; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin tick(); seen = fall[1]; end
    chk("rep_fall_seen", seen, 1);
    fs = 0;
    repeat (30) begin tick(); fs |= rep; end
    chk("rep_after_fall", fs, 0);

    // reset mid-repeat on ch1 and mid-count on ch2
    raw = 4'b0010;
    repeat (80) tick();
    raw = 4'b0110;
    repeat (15) tick();
    chk("pre_reset_stable", stable, 4'b0010);
    #2 reset = 1'b0;
    model_reset();
    #1 chk_zero("async_reset");
    @(negedge clk) reset = 1'b1;
    n = 0; at = -1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (rise == 4'b0110) begin n++; at = k; end
    end
    chk("requal_n", n, 1);
    chk("requal_at", at, 22);

    // random segments
    for (int g = 0; g < 120; g++) begin
      raw = 4'($urandom);
      repeat ($urandom_range(1, 90)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
